// File: rtl/reflet_irq_ctrl.sv
// reflet_irq_ctrl
// ---------------
// Memory-mapped interrupt controller that sits in front of reflet_cpu. It
// collects four external interrupt lines, latches them as pending, masks
// them and drives the CPU's 4-bit interrupt_request input. The CPU
// configures and acknowledges it through its ordinary data bus. The read
// data is meant to be OR-ed onto the CPU's data_in next to ROM/RAM, so it is
// zero whenever the window is not addressed.
//
// Register window (index = (addr - base_addr) / (wordsize/8)):
//   0 STATUS (RO) bits[3:0] pending
//   1 ENABLE (RW) bits[3:0] request mask, resets to 0
//   2 MODE   (RW) bit=1 edge-triggered, bit=0 level, resets to 4'hF
//   3 CLEAR  (WO) writing 1 to bit n clears edge-pending bit n, reads 0
//
// Parameters:
//   wordsize  CPU word width in bits (8, 16, 32 or 64)
//   base_addr byte address of the window, aligned to 4 words
//
// Ports:
//   clk               system clock, all state on the rising edge
//   reset             asynchronous, active-low; 0 clears all state
//   enable            0 freezes every register, synchronizers included
//   irq_in[3:0]       external interrupt sources
//   addr              CPU byte address
//   data_in           CPU write data (the CPU's data_out)
//   write_en          CPU write strobe
//   data_out          registered read data, 0 when not addressed
//   interrupt_request pending & ENABLE, straight from flops
//
// Build option:
//   REFLET_IRQ_SYNC_EN  when defined, irq_in passes through a 2-flop
//                       synchronizer per line so asynchronous sources are
//                       safe (adds 2 cycles of latency). When undefined,
//                       irq_in is used directly and must be synchronous.

module reflet_irq_ctrl #(
  parameter int                  wordsize  = 16,
  parameter logic [wordsize-1:0] base_addr = 16'hFF00
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [3:0]          irq_in,
  input  logic [wordsize-1:0] addr,
  input  logic [wordsize-1:0] data_in,
  input  logic                write_en,
  output logic [wordsize-1:0] data_out,
  output logic [3:0]          interrupt_request
);

  // Byte offset of a register inside the window is word-aligned, so the low
  // address bits that select a byte within a word carry no information.
  localparam int BYTES_PER_WORD = wordsize / 8;
  localparam int ADDR_SHIFT     = $clog2(BYTES_PER_WORD);

  localparam logic [1:0] IDX_STATUS = 2'd0;
  localparam logic [1:0] IDX_ENABLE = 2'd1;
  localparam logic [1:0] IDX_MODE   = 2'd2;
  localparam logic [1:0] IDX_CLEAR  = 2'd3;

  logic [3:0]          s;
  logic [3:0]          s_prev;
  logic [3:0]          pending;
  logic [3:0]          pending_next;
  logic [3:0]          irq_enable;
  logic [3:0]          irq_mode;
  logic [3:0]          clear_bits;
  logic [3:0]          rise;
  logic [wordsize-1:0] offset;
  logic [wordsize-1:0] read_value;
  logic [1:0]          reg_index;
  logic                in_window;
  logic                bus_write;
  logic                unused_bits;

  // Input conditioning: either a 2-flop synchronizer per line, or a direct
  // connection when the sources are already in the clk domain.
`ifdef REFLET_IRQ_SYNC_EN
  logic [3:0] sync_meta;
  logic [3:0] sync_out;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_meta <= 4'h0;
      sync_out  <= 4'h0;
    end else if (enable) begin
      sync_meta <= irq_in;
      sync_out  <= sync_meta;
    end
  end

  assign s = sync_out;
`else
  assign s = irq_in;
`endif

  // Address decode. The subtraction wraps, so addresses below base_addr land
  // far outside the window and are rejected by the upper-bit test.
  assign offset    = addr - base_addr;
  assign in_window = (offset[wordsize-1:ADDR_SHIFT+2] == '0);
  assign reg_index = offset[ADDR_SHIFT+1:ADDR_SHIFT];
  assign bus_write = enable & write_en & in_window;

  assign clear_bits = (bus_write && (reg_index == IDX_CLEAR)) ? data_in[3:0] : 4'h0;

  // Upper data bits and byte-select address bits are intentionally ignored.
  assign unused_bits = ^{data_in[wordsize-1:4], offset};

  // Pending update. Edge-mode bits set on a rising edge of s and hold until
  // cleared; the set term is OR-ed last so an edge coinciding with a clear
  // wins. Level-mode bits simply track s. The mode used is the one currently
  // in the register, so a MODE write only changes the rule from the next edge.
  assign rise = s & ~s_prev;

  always_comb begin
    pending_next = (irq_mode & (rise | (pending & ~clear_bits)))
                 | (~irq_mode & s);
  end

  // Read mux: zero outside the window and for the write-only CLEAR register,
  // so the result can be OR-ed onto the shared CPU read bus.
  always_comb begin
    read_value = '0;
    if (in_window) begin
      case (reg_index)
        IDX_STATUS: read_value[3:0] = pending;
        IDX_ENABLE: read_value[3:0] = irq_enable;
        IDX_MODE:   read_value[3:0] = irq_mode;
        default:    read_value      = '0;
      endcase
    end
  end

  // All architectural state. Everything freezes while enable is low; data_out
  // samples the pre-update registers, so a STATUS read racing a pending
  // change returns the old value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_prev     <= 4'h0;
      pending    <= 4'h0;
      irq_enable <= 4'h0;
      irq_mode   <= 4'hF;
      data_out   <= '0;
    end else if (enable) begin
      s_prev   <= s;
      pending  <= pending_next;
      data_out <= read_value;
      if (bus_write && (reg_index == IDX_ENABLE)) begin
        irq_enable <= data_in[3:0];
      end
      if (bus_write && (reg_index == IDX_MODE)) begin
        irq_mode <= data_in[3:0];
      end
    end
  end

  // Pure AND of two flop outputs, so the request line cannot glitch.
  assign interrupt_request = pending & irq_enable;

endmodule

// File: tb/tb_reflet_irq_ctrl.sv
// Testbench for reflet_irq_ctrl (wordsize 16, base_addr 16'hFF00).
// Directed steps walk through reset, edge latch/clear, masking, level mode,
// simultaneous set/clear, bus isolation, freeze and asynchronous reset, then
// a randomized phase. Every cycle the DUT outputs are compared with a
// behavioural model that keeps a history of sampled irq_in values and
// applies the controller's rules to it. Latency adapts to whether
// REFLET_IRQ_SYNC_EN is defined.

module tb_reflet_irq_ctrl;

  localparam logic [15:0] BASE = 16'hFF00;
`ifdef REFLET_IRQ_SYNC_EN
  localparam int SYNC_STAGES = 2;
`else
  localparam int SYNC_STAGES = 0;
`endif
  // Edges from irq_in rising to interrupt_request rising in edge mode.
  localparam int LAT = SYNC_STAGES + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b1;
  logic        write_en = 1'b0;
  logic [3:0]  irq_in = 4'h0;
  logic [15:0] addr = 16'h0;
  logic [15:0] data_in = 16'h0;
  logic [15:0] data_out;
  logic [3:0]  interrupt_request;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state.
  logic [3:0]  m_pend;
  logic [3:0]  m_en;
  logic [3:0]  m_mode;
  logic [15:0] m_dout;
  logic [3:0]  hist[$];

  always #5 clk = ~clk;

  reflet_irq_ctrl #(
    .wordsize (16),
    .base_addr(16'hFF00)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .irq_in           (irq_in),
    .addr             (addr),
    .data_in          (data_in),
    .write_en         (write_en),
    .data_out         (data_out),
    .interrupt_request(interrupt_request)
  );

  task automatic check_output(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic void model_reset();
    m_pend = 4'h0;
    m_en   = 4'h0;
    m_mode = 4'hF;
    m_dout = 16'h0;
    hist.delete();
    for (int i = 0; i <= SYNC_STAGES; i++) hist.push_back(4'h0);
  endfunction

  // One enabled rising edge of the controller, from the register-map rules.
  function automatic void model_edge();
    logic [15:0] off;
    int          idx;
    bit          hit;
    logic [3:0]  s_now;
    logic [3:0]  s_old;
    logic [3:0]  clr;
    off = addr - BASE;
    hit = (off < 16'd8);
    idx = int'(off) / 2;
    m_dout = 16'h0;
    if (hit) begin
      if (idx == 0) m_dout = {12'h0, m_pend};
      if (idx == 1) m_dout = {12'h0, m_en};
      if (idx == 2) m_dout = {12'h0, m_mode};
    end
    hist.push_back(irq_in);
    s_now = hist[hist.size() - 1 - SYNC_STAGES];
    s_old = hist[hist.size() - 2 - SYNC_STAGES];
    while (hist.size() > SYNC_STAGES + 1) void'(hist.pop_front());
    clr = (write_en && hit && idx == 3) ? data_in[3:0] : 4'h0;
    for (int n = 0; n < 4; n++) begin
      if (m_mode[n]) begin
        if (s_now[n] && !s_old[n]) m_pend[n] = 1'b1;
        else if (clr[n]) m_pend[n] = 1'b0;
      end else begin
        m_pend[n] = s_now[n];
      end
    end
    if (write_en && hit && idx == 1) m_en = data_in[3:0];
    if (write_en && hit && idx == 2) m_mode = data_in[3:0];
  endfunction

  // Drive one bus cycle, clock it, and compare both outputs with the model.
  task automatic apply_stimulus(input logic we, input logic [15:0] a,
                                input logic [15:0] d, input logic [3:0] irq);
    write_en = we;
    addr     = a;
    data_in  = d;
    irq_in   = irq;
    @(posedge clk);
    if (reset && enable) model_edge();
    #1;
    check_output("model_irq_req", {12'h0, interrupt_request}, {12'h0, m_pend & m_en});
    check_output("model_data_out", data_out, m_dout);
  endtask

  initial begin
    model_reset();

    // Reset values while reset is held low.
    #12;
    check_output("reset_irq_req", {12'h0, interrupt_request}, 16'h0);
    check_output("reset_data_out", data_out, 16'h0);
    @(negedge clk);
    reset = 1'b1;

    apply_stimulus(1'b0, 16'hFF04, 16'h0, 4'h0);
    check_output("reset_mode_read", data_out, 16'h000F);
    apply_stimulus(1'b0, 16'hFF00, 16'h0, 4'h0);
    check_output("reset_status_read", data_out, 16'h0000);

    // Edge latch: ENABLE=5, one-cycle pulse on irq_in[0].
    apply_stimulus(1'b1, 16'hFF02, 16'h0005, 4'h0);
    apply_stimulus(1'b0, 16'h0000, 16'h0, 4'h1);
    check_output("edge_latency_1", {12'h0, interrupt_request}, (LAT == 1) ? 16'h1 : 16'h0);
    for (int k = 2; k <= LAT + 2; k++) begin
      apply_stimulus(1'b0, 16'h0000, 16'h0, 4'h0);
      check_output("edge_latency_n", {12'h0, interrupt_request}, (k >= LAT) ? 16'h1 : 16'h0);
    end

    // Clear it.
    apply_stimulus(1'b1, 16'hFF06, 16'h0001, 4'h0);
    check_output("clear_irq_req", {12'h0, interrupt_request}, 16'h0);
    apply_stimulus(1'b0, 16'hFF00, 16'h0, 4'h0);
    check_output("clear_status", data_out, 16'h0);

    // Masking: ENABLE=0, edge on irq_in[2].
    apply_stimulus(1'b1, 16'hFF02, 16'h0000, 4'h0);
    for (int k = 0; k <= LAT; k++) apply_stimulus(1'b0, 16'h0000, 16'h0, 4'h4);
    check_output("mask_irq_req", {12'h0, interrupt_request}, 16'h0);
    apply_stimulus(1'b0, 16'hFF00, 16'h0, 4'h4);
    check_output("mask_status", data_out, 16'h0004);
    apply_stimulus(1'b1, 16'hFF02, 16'h0004, 4'h4);
    check_output("unmask_irq_req", {12'h0, interrupt_request}, 16'h4);

    // Level mode on irq_in[1].
    apply_stimulus(1'b1, 16'hFF04, 16'h0000, 4'h0);
    apply_stimulus(1'b1, 16'hFF02, 16'h0002, 4'h0);
    for (int k = 0; k <= LAT; k++) apply_stimulus(1'b0, 16'h0000, 16'h0, 4'h2);
    check_output("level_irq_req", {12'h0, interrupt_request}, 16'h2);
    apply_stimulus(1'b1, 16'hFF06, 16'h0002, 4'h2);
    check_output("level_clear_ignored", {12'h0, interrupt_request}, 16'h2);
    for (int k = 1; k <= LAT; k++) begin
      apply_stimulus(1'b0, 16'h0000, 16'h0, 4'h0);
      check_output("level_drop", {12'h0, interrupt_request}, (k >= LAT) ? 16'h0 : 16'h2);
    end

    // Simultaneous set and clear on bit 3.
    apply_stimulus(1'b1, 16'hFF04, 16'h000F, 4'h0);
    apply_stimulus(1'b1, 16'hFF02, 16'h000F, 4'h0);
    apply_stimulus(1'b1, 16'hFF06, 16'h000F, 4'h0);
    for (int k = 1; k <= LAT; k++) apply_stimulus(k == LAT, 16'hFF06, 16'h0008, 4'h8);
    check_output("set_wins_irq_req", {12'h0, interrupt_request}, 16'h8);
    apply_stimulus(1'b0, 16'hFF00, 16'h0, 4'h8);
    check_output("set_wins_status", data_out, 16'h0008);

    // Bus isolation.
    apply_stimulus(1'b0, 16'h1234, 16'h0, 4'h8);
    check_output("out_of_window_read", data_out, 16'h0);
    apply_stimulus(1'b1, 16'hFF08, 16'hFFF0, 4'h8);
    apply_stimulus(1'b1, 16'hFF00, 16'hFFF0, 4'h8);
    apply_stimulus(1'b0, 16'hFF02, 16'h0, 4'h8);
    check_output("isolation_enable_kept", data_out, 16'h000F);
    apply_stimulus(1'b0, 16'hFF04, 16'h0, 4'h8);
    check_output("isolation_mode_kept", data_out, 16'h000F);

    // Freeze: clear, then edge and ENABLE write with enable low.
    apply_stimulus(1'b1, 16'hFF06, 16'h000F, 4'h0);
    enable = 1'b0;
    for (int k = 0; k <= LAT + 1; k++) apply_stimulus(1'b1, 16'hFF02, 16'h0000, 4'h1);
    check_output("freeze_irq_req", {12'h0, interrupt_request}, 16'h0);
    enable = 1'b1;
    apply_stimulus(1'b0, 16'hFF02, 16'h0, 4'h1);
    check_output("freeze_enable_kept", data_out, 16'h000F);
    apply_stimulus(1'b1, 16'hFF06, 16'h000F, 4'h0);
    for (int k = 0; k <= LAT; k++) apply_stimulus(1'b1, 16'hFF06, 16'h000F, 4'h0);

    // Randomized phase.
    for (int k = 0; k < 400; k++) begin
      logic [15:0] ra;
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 3) != 0) ra = BASE + 16'($urandom_range(0, 7));
      else ra = 16'($urandom);
      apply_stimulus(1'($urandom), ra, 16'($urandom), 4'($urandom));
    end
    enable = 1'b1;

    // Asynchronous reset with requests pending.
    apply_stimulus(1'b1, 16'hFF02, 16'h000F, 4'hF);
    apply_stimulus(1'b1, 16'hFF04, 16'h0000, 4'hF);
    for (int k = 0; k <= LAT; k++) apply_stimulus(1'b0, 16'h0000, 16'h0, 4'hF);
    check_output("pre_reset_irq_req", {12'h0, interrupt_request}, 16'hF);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_output("async_reset_irq_req", {12'h0, interrupt_request}, 16'h0);
    check_output("async_reset_data_out", data_out, 16'h0);
    @(negedge clk);
    reset = 1'b1;
    apply_stimulus(1'b0, 16'hFF04, 16'h0, 4'h0);
    check_output("post_reset_mode", data_out, 16'h000F);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/reflet_irq_ctrl.md
# reflet_irq_ctrl

Memory-mapped interrupt controller sitting directly upstream of `reflet_cpu`: it collects four external interrupt lines, latches them as pending, masks them, and drives the CPU's 4-bit `interrupt_request` input. The CPU configures and acknowledges it through its ordinary data bus (`addr`, `data_out`, `write_en`). The controller's read data is OR-ed onto the CPU's `data_in` alongside the ROM/RAM.

## Interface
- `wordsize`, default 16: CPU word width in bits; must be 8, 16, 32 or 64.
- `base_addr`, default 16'hFF00 (width `wordsize`): byte address of the register window; aligned to 4*`wordsize`/8.

Ports:
- `clk`  in  1: system clock, all state on rising edge.
- `reset`  in  1: asynchronous, active-low; 0 clears all state.
- `enable`  in  1: 0 freezes all registers (including synchronizers); outputs hold.
- `irq_in`  in  4: external interrupt sources, may be asynchronous to `clk`.
- `addr`  in  `wordsize`: CPU byte address.
- `data_in`  in  `wordsize`: CPU write data (CPU's `data_out`).
- `write_en`  in  1: CPU write strobe.
- `data_out`  out  `wordsize`: registered read data; 0 when not addressed.
- `interrupt_request`  out  4: to CPU `interrupt_request`.

## Operation
- Register map, index = (`addr` - `base_addr`) / (`wordsize`/8); the low log2(`wordsize`/8) address bits are ignored:
  - 0 STATUS (RO): bits[3:0] = pending; upper bits 0.
  - 1 ENABLE (RW): bits[3:0] mask; reset 4'h0.
  - 2 MODE (RW): bit=1 edge-triggered, bit=0 level; reset 4'hF.
  - 3 CLEAR (WO): writing 1 to bit n clears edge-pending bit n; reads 0.
- Writes outside the window, or to STATUS, are ignored. Bits above 3 are ignored on write.
- Input path: `irq_in` goes to `s` (see Configuration), then a one-flop `s_prev`.
- Edge-mode bit n:
  - pending set when `s[n]`=1 and `s_prev[n]`=0.
  - cleared by a CLEAR write with bit n=1.
  - An edge in the same cycle as a clear leaves pending = 1 (set wins).
- Level-mode bit n: pending <= `s[n]` every cycle; CLEAR has no effect.
- Switching MODE keeps the current pending value; the new rule applies from the next edge.
- Writing ENABLE never alters pending.
- `interrupt_request` = pending & ENABLE, combinational from registers only (glitch-free).
- Reset: pending, ENABLE, `s`, `s_prev` and `data_out` all go to 0; MODE goes to 4'hF. `interrupt_request` is 0. Reset mid-operation discards pending edges immediately.

## Timing
- Read latency 1 cycle: at the rising edge with `enable`=1, `data_out` <= register selected by `addr`, or 0 when out of window. This matches the registered ROM so the CPU sees the data the cycle after presenting `addr`.
- Write takes effect at the rising edge where `write_en`=1 and `enable`=1. A read in the following cycle returns the new value.
- STATUS read in the same cycle as a pending update returns the pre-update value.
- `irq_in` rise to `interrupt_request` rise (ENABLE bit set, edge mode):
  - 3 rising edges with `REFLET_IRQ_SYNC_EN`;
  - 1 edge without it.
- CLEAR write at edge k: `interrupt_request` bit falls after edge k.
- ENABLE write at edge k: `interrupt_request` bit follows after edge k.

## Configuration
- `REFLET_IRQ_SYNC_EN` defined: `s` is the output of a 2-flop synchronizer per line. Asynchronous sources are safe; latency is +2 cycles.
- `REFLET_IRQ_SYNC_EN` undefined: `s` = `irq_in` directly. `irq_in` must be synchronous to `clk`.

## Test plan
Common setup: `wordsize`=16, `base_addr`=FF00, `REFLET_IRQ_SYNC_EN` defined.
- Reset values: hold `reset`=0 -> `interrupt_request`=0, `data_out`=0. Release and read FF04 -> 16'h000F. Read FF00 -> 0.
- Edge latch and clear:
  - Write FF02=16'h0005; pulse `irq_in[0]` high for 1 cycle -> `interrupt_request`=4'h1 exactly 3 edges after the rise, and it stays set after `irq_in` falls.
  - Write FF06=16'h0001 -> `interrupt_request`=0. Read FF00 -> 0.
- Masking: ENABLE=0, edge on `irq_in[2]` -> `interrupt_request`=0 and STATUS=16'h0004. Write ENABLE=16'h0004 -> `interrupt_request`=4'h4 after that edge.
- Level mode: write MODE=16'h0000, ENABLE=16'h0002. Hold `irq_in[1]`=1 -> request 4'h2. Write CLEAR=16'h0002 -> request stays 4'h2. Drop `irq_in[1]` -> request 0 three edges later.
- Simultaneous set/clear: rising edge reaches `s` in the same cycle as a CLEAR write to that bit -> pending and request remain 1.
- Bus isolation and freeze:
  - Read 16'h1234 -> `data_out`=0. Write 16'hFF08 -> no register changes.
  - With `enable`=0, an `irq_in` edge and an ENABLE write both have no effect.
  - Asserting `reset`=0 while requests are pending -> `interrupt_request`=0 immediately, without waiting for a clock edge.
